gpio_in_filter: RTL

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

---
 rtl/croc_pkg.sv | 5 +
 rtl/gpio_in_filter_chan.sv | 75 +++++++
 rtl/gpio_in_filter.sv | 41 ++++
 3 files changed

// File: rtl/croc_pkg.sv
// Chip-level constants shared by croc peripherals, including the GPIO input filter defaults.
package croc_pkg;
  localparam int unsigned GpioCount           = 20;
  localparam int unsigned GpioFilterDebounceW = 8;
endpackage

// File: rtl/gpio_in_filter_chan.sv
// One pad bit: 2-flop sync, debounce counter, filtered level, edge pulses, optional sticky pending.
// Pending flop exists only when GPIO_FILTER_IRQ_EN is defined.
module gpio_in_filter_chan #(
  parameter int unsigned DebounceW = croc_pkg::GpioFilterDebounceW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pad_i,
  input  logic [DebounceW-1:0] cfg_i,
  input  logic                 rise_en_i,
  input  logic                 fall_en_i,
  input  logic                 irq_clr_i,
  output logic                 filt_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 pending_o
);

  logic                 s1, s2, filt_q, rise_q, fall_q;
  logic [DebounceW-1:0] cnt_q;
  logic                 flip;

  // >= rather than == so a lowered cfg takes effect on the very next edge
  assign flip = (s2 != filt_q) && (cnt_q >= cfg_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1 <= pad_i;
      s2 <= s1;
      if (s2 == filt_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        filt_q <= s2;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      rise_q <= flip & s2;
      fall_q <= flip & ~s2;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef GPIO_FILTER_IRQ_EN
  logic pend_q;

  // set has priority over clear so an edge coinciding with a clear is never lost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
    end else if ((rise_q & rise_en_i) | (fall_q & fall_en_i)) begin
      pend_q <= 1'b1;
    end else if (irq_clr_i) begin
      pend_q <= 1'b0;
    end
  end

  assign pending_o = pend_q;
`else
  logic unused_irq_ctrl;
  assign unused_irq_ctrl = rise_en_i ^ fall_en_i ^ irq_clr_i;
  assign pending_o       = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// Debounce/edge-detect filter for GpioCount pad inputs; one gpio_in_filter_chan per pin.
// Define GPIO_FILTER_IRQ_EN to build the sticky pending flags and irq_o; otherwise both read 0.
module gpio_in_filter #(
  parameter int unsigned GpioCount = croc_pkg::GpioCount,
  parameter int unsigned DebounceW = croc_pkg::GpioFilterDebounceW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GpioCount-1:0] gpio_i,
  input  logic [DebounceW-1:0] debounce_cfg_i,
  input  logic [GpioCount-1:0] rise_en_i,
  input  logic [GpioCount-1:0] fall_en_i,
  input  logic [GpioCount-1:0] irq_clr_i,
  output logic [GpioCount-1:0] gpio_filt_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o,
  output logic [GpioCount-1:0] irq_pending_o,
  output logic                 irq_o
);

  for (genvar g = 0; g < GpioCount; g++) begin : g_chan
    gpio_in_filter_chan #(
      .DebounceW(DebounceW)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pad_i     (gpio_i[g]),
      .cfg_i     (debounce_cfg_i),
      .rise_en_i (rise_en_i[g]),
      .fall_en_i (fall_en_i[g]),
      .irq_clr_i (irq_clr_i[g]),
      .filt_o    (gpio_filt_o[g]),
      .rise_o    (rise_o[g]),
      .fall_o    (fall_o[g]),
      .pending_o (irq_pending_o[g])
    );
  end

  assign irq_o = |irq_pending_o;

endmodule
